snake_body_ctrl: RTL and testbench

Owns the snake itself: holds the body segment buffer, advances the head one grid cell per game tick, grows the snake on an apple hit, and detects wall and self collisions. Drives head_x/head_y to the apple-eating block and consumes that block's apple_x/apple_y. Also answers per-pixel-cell "is this a body cell" queries from the VGA renderer.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_body_ctrl_if.sv | 37 +++
 rtl/snake_seg_match.sv | 25 ++
 rtl/snake_body_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks.
//   - Coordinate widths: x is 6 bits and y is 5 bits.
//   - Default grid bounds: the legal cells are 1..X_MAX and 1..Y_MAX.
//   - Direction encoding, which is also the encoding on the dir_req port.
//   - Body-controller FSM state encoding.
//   - is_reverse(): true when two directions are exact opposites.
package snake_pkg;

    localparam int X_W   = 6;
    localparam int Y_W   = 5;
    localparam int X_MAX = 38;
    localparam int Y_MAX = 28;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Opposite directions differ by exactly two in this encoding.
    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (a ^ b) == 2'd2;
    endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// Bundles the game-side signals of snake_body_ctrl.
//   - master (game/testbench side) drives:
//       dir_req, dir_valid, apple_x, apple_y, query_x, query_y.
//   - slave (snake_body_ctrl side) drives:
//       head_x, head_y, length, grow, move_tick, game_over,
//       query_hit, query_head.
interface snake_body_ctrl_if;
    import snake_pkg::*;

    logic [1:0]     dir_req;
    logic           dir_valid;
    logic [X_W-1:0] apple_x;
    logic [Y_W-1:0] apple_y;
    logic [X_W-1:0] query_x;
    logic [Y_W-1:0] query_y;
    logic [5:0]     head_x;
    logic [5:0]     head_y;
    logic [4:0]     length;
    logic           grow;
    logic           move_tick;
    logic           game_over;
    logic           query_hit;
    logic           query_head;

    modport master (
        output dir_req, dir_valid, apple_x, apple_y, query_x, query_y,
        input  head_x, head_y, length, grow, move_tick, game_over,
               query_hit, query_head
    );

    modport slave (
        input  dir_req, dir_valid, apple_x, apple_y, query_x, query_y,
        output head_x, head_y, length, grow, move_tick, game_over,
               query_hit, query_head
    );

endinterface

// File: rtl/snake_seg_match.sv
// Combinational coordinate-versus-segment comparator.
//   Inputs:
//     x, y          coordinate under test
//     seg_x, seg_y  segment buffer
//     live          segments that may match
//   Output:
//     match[i]      set when segment i is live and sits at (x, y)
module snake_seg_match
    import snake_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [X_W-1:0]         x,
    input  logic [Y_W-1:0]         y,
    input  logic [N-1:0][X_W-1:0]  seg_x,
    input  logic [N-1:0][Y_W-1:0]  seg_y,
    input  logic [N-1:0]           live,
    output logic [N-1:0]           match
);

    for (genvar i = 0; i < N; i++) begin : g_cmp
        assign match[i] = live[i] && (seg_x[i] == x) && (seg_y[i] == y);
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller.
//   Function:
//     - Holds the body segment buffer.
//     - Moves the head one cell every TICK_CYCLES clocks.
//     - Grows the snake on an apple hit.
//     - Detects wall and self collisions.
//     - Answers renderer "is this a body cell" queries.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-low
//     bus    snake_body_ctrl_if.slave:
//              dir_req/dir_valid  direction requests
//              apple_x/apple_y    sampled only on the move cycle
//              query_x/query_y    renderer query; query_hit/query_head
//                                 answer one cycle later
//              head_x/head_y      segment 0
//              length             current length
//              grow               one-cycle pulse on a growing move
//              move_tick          one-cycle pulse on every head update
//              game_over          high while in DEAD
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int START_LEN   = 3,
    parameter int START_X     = 10,
    parameter int START_Y     = 10,
    parameter int X_MAX       = snake_pkg::X_MAX,
    parameter int Y_MAX       = snake_pkg::Y_MAX,
    parameter int TICK_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               reset,
    snake_body_ctrl_if.slave   bus
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_e                        state_q, state_d;
    dir_e                          dir_q, dir_d;
    dir_e                          pend_q, pend_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [4:0]                    len_q, len_d;
    logic [MAX_LEN-1:0][X_W-1:0]   seg_x_q, seg_x_d;
    logic [MAX_LEN-1:0][Y_W-1:0]   seg_y_q, seg_y_d;
    logic                          grow_q, grow_d;
    logic                          move_q, move_d;
    logic                          query_hit_q, query_hit_d;
    logic                          query_head_q, query_head_d;

    dir_e                          req_dir;
    logic                          move_now;
    logic [5:0]                    nh_x;
    logic [5:0]                    nh_y;
    logic                          wall_hit;
    logic                          eat;
    logic                          grow_ok;
    logic                          self_hit;
    logic [MAX_LEN-1:0]            len_mask;
    logic [MAX_LEN-1:0]            col_mask;
    logic [MAX_LEN-1:0]            col_match;
    logic [MAX_LEN-1:0]            q_match;

    assign req_dir  = dir_e'(bus.dir_req);
    assign move_now = (cnt_q == CNT_W'(TICK_CYCLES - 1));

    // Next head position from the pending direction, in 6-bit arithmetic.
    // An underflow wraps to 63, which the wall check treats as out of range.
    always_comb begin
        nh_x = seg_x_q[0];
        nh_y = {1'b0, seg_y_q[0]};
        unique case (pend_q)
            DIR_UP:    nh_y = nh_y - 6'd1;
            DIR_RIGHT: nh_x = nh_x + 6'd1;
            DIR_DOWN:  nh_y = nh_y + 6'd1;
            default:   nh_x = nh_x - 6'd1;
        endcase
    end

    assign wall_hit = (nh_x == 6'd0) || (nh_x > 6'(X_MAX)) ||
                      (nh_y == 6'd0) || (nh_y > 6'(Y_MAX));
    assign eat      = (nh_x == bus.apple_x) && (nh_y == {1'b0, bus.apple_y});
    assign grow_ok  = eat && (len_q < 5'(MAX_LEN));

    // Live segments are those below length.
    // The tail is excluded from the collision set unless the snake grows,
    // because a non-growing move vacates the tail cell.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
        assign len_mask[i] = (5'(i) < len_q);
        assign col_mask[i] = len_mask[i] && !(!grow_ok && (5'(i) == len_q - 5'd1));
    end

    snake_seg_match #(.N(MAX_LEN)) u_self_match (
        .x     (nh_x),
        .y     (nh_y[Y_W-1:0]),
        .seg_x (seg_x_q),
        .seg_y (seg_y_q),
        .live  (col_mask),
        .match (col_match)
    );

    snake_seg_match #(.N(MAX_LEN)) u_query_match (
        .x     (bus.query_x),
        .y     (bus.query_y),
        .seg_x (seg_x_q),
        .seg_y (seg_y_q),
        .live  (len_mask),
        .match (q_match)
    );

    assign self_hit     = |col_match;
    assign query_hit_d  = |q_match;
    assign query_head_d = q_match[0];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        grow_d  = 1'b0;
        move_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.dir_valid) begin
                    if (!is_reverse(req_dir, dir_q)) begin
                        pend_d = req_dir;
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (move_now) begin
                    cnt_d = '0;
                    dir_d = pend_q;
                    if (wall_hit || self_hit) begin
                        state_d = ST_DEAD;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nh_x;
                        seg_y_d[0] = nh_y[Y_W-1:0];
                        move_d     = 1'b1;
                        if (grow_ok) begin
                            len_d  = len_q + 5'd1;
                            grow_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A request on the move cycle is judged against the
                // direction being committed and takes effect next move.
                if (bus.dir_valid && !is_reverse(req_dir, move_now ? pend_q : dir_q)) begin
                    pend_d = req_dir;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            cnt_q        <= '0;
            len_q        <= 5'(START_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= X_W'(START_X - i);
                seg_y_q[i] <= Y_W'(START_Y);
            end
            grow_q       <= 1'b0;
            move_q       <= 1'b0;
            query_hit_q  <= 1'b0;
            query_head_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            seg_x_q      <= seg_x_d;
            seg_y_q      <= seg_y_d;
            grow_q       <= grow_d;
            move_q       <= move_d;
            query_hit_q  <= query_hit_d;
            query_head_q <= query_head_d;
        end
    end

    assign bus.head_x     = seg_x_q[0];
    assign bus.head_y     = {1'b0, seg_y_q[0]};
    assign bus.length     = len_q;
    assign bus.grow       = grow_q;
    assign bus.move_tick  = move_q;
    assign bus.game_over  = (state_q == ST_DEAD);
    assign bus.query_hit  = query_hit_q;
    assign bus.query_head = query_head_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Testbench for snake_body_ctrl.
//   - Reference model: the body is a queue of cells with the head at the
//     front. A move pushes the new head and drops the tail unless the
//     snake grows.
//   - Expected move/death events and per-cycle query answers are queued
//     as stimulus is applied.
//   - A monitor on the falling edge pops and compares them.
module tb_snake_body_ctrl;

    localparam int T    = 4;
    localparam int MAXL = 16;
    localparam int SX   = 10;
    localparam int SY   = 10;
    localparam int XM   = 38;
    localparam int YM   = 28;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snake_body_ctrl_if bus();

    snake_body_ctrl #(
        .MAX_LEN(MAXL), .START_LEN(3), .START_X(SX), .START_Y(SY),
        .X_MAX(XM), .Y_MAX(YM), .TICK_CYCLES(T)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {bit dead; int hx; int hy; int len; bit grow;} ev_t;
    typedef struct {bit hit; bit head;} qx_t;
    ev_t ev_q[$];
    qx_t qx_q[$];

    // Reference model state: 0 idle, 1 running, 2 dead.
    int m_state, m_cnt, m_dir, m_pend;
    int m_moves = 0;
    int bx[$];
    int by[$];
    bit q_rand = 1'b1;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_rev(int a, int b);
        return ((a + 2) % 4) == b;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_dir = 1; m_pend = 1;
        bx.delete(); by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(SX - i);
            by.push_back(SY);
        end
    endtask

    // Advance the model by one clock edge, using the inputs the DUT sees.
    task automatic model_step();
        qx_t q;
        ev_t e;
        int nx, ny;
        bit eat, gok, hit;
        q.hit = 1'b0; q.head = 1'b0;
        if (rst_n) begin
            for (int i = 0; i < bx.size(); i++)
                if (bx[i] == int'(bus.query_x) && by[i] == int'(bus.query_y)) begin
                    q.hit = 1'b1;
                    if (i == 0) q.head = 1'b1;
                end
        end
        qx_q.push_back(q);
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (bus.dir_valid) begin
                if (!is_rev(int'(bus.dir_req), m_dir)) m_pend = int'(bus.dir_req);
                m_state = 1;
                m_cnt = 0;
            end
            1: if (m_cnt == T - 1) begin
                m_cnt = 0;
                m_dir = m_pend;
                nx = bx[0] + ((m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0);
                ny = by[0] + ((m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0);
                eat = (nx == int'(bus.apple_x)) && (ny == int'(bus.apple_y));
                gok = eat && (bx.size() < MAXL);
                hit = 1'b0;
                for (int i = 0; i < bx.size(); i++)
                    if (!(i == bx.size() - 1 && !gok) && bx[i] == nx && by[i] == ny) hit = 1'b1;
                if (nx < 1 || nx > XM || ny < 1 || ny > YM || hit) begin
                    m_state = 2;
                    e.dead = 1'b1; e.grow = 1'b0;
                end else begin
                    bx.push_front(nx); by.push_front(ny);
                    if (!gok) begin
                        void'(bx.pop_back());
                        void'(by.pop_back());
                    end
                    e.dead = 1'b0; e.grow = gok;
                end
                e.hx = bx[0]; e.hy = by[0]; e.len = bx.size();
                ev_q.push_back(e);
                m_moves++;
            end else begin
                m_cnt++;
                if (bus.dir_valid && !is_rev(int'(bus.dir_req), m_dir)) m_pend = int'(bus.dir_req);
            end
            default: ;
        endcase
    endtask

    // One clock: model follows the edge, then new inputs are driven.
    task automatic cyc();
        int r, k;
        @(posedge clk);
        model_step();
        #1;
        rst_n = 1'b1;
        bus.dir_valid = 1'b0;
        if (q_rand) begin
            r = $urandom_range(0, 3);
            case (r)
                0: begin
                    bus.query_x = 6'($urandom_range(0, 40));
                    bus.query_y = 5'($urandom_range(0, 30));
                end
                1: begin
                    k = $urandom_range(0, bx.size() - 1);
                    bus.query_x = 6'(bx[k]);
                    bus.query_y = 5'(by[k]);
                end
                2: begin
                    k = $urandom_range(0, 15);
                    bus.query_x = 6'((SX - k) & 63);
                    bus.query_y = 5'(SY);
                end
                default: begin
                    bus.query_x = 6'(bx[0]);
                    bus.query_y = 5'(by[0]);
                end
            endcase
        end
    endtask

    task automatic req(int d);
        if (m_state == 1 && m_cnt == T - 1) cyc();
        bus.dir_req = 2'(d);
        bus.dir_valid = 1'b1;
        cyc();
    endtask

    task automatic wait_move();
        int n;
        n = m_moves;
        for (int k = 0; k < 2 * T + 2 && m_moves == n; k++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        chk("rst_head_x", int'(bus.head_x), SX);
        chk("rst_head_y", int'(bus.head_y), SY);
        chk("rst_length", int'(bus.length), 3);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_move_tick", int'(bus.move_tick), 0);
        chk("rst_grow", int'(bus.grow), 0);
        chk("rst_query_hit", int'(bus.query_hit), 0);
    endtask

    task automatic set_apple(int x, int y);
        bus.apple_x = 6'(x);
        bus.apple_y = 5'(y);
    endtask

    // Monitor: checks every query answer and every move/death event.
    initial begin
        bit prev_go;
        ev_t e;
        qx_t q;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (qx_q.size() > 0) begin
                q = qx_q.pop_front();
                chk("query_hit", int'(bus.query_hit), int'(q.hit));
                chk("query_head", int'(bus.query_head), int'(q.head));
            end
            if (bus.move_tick || bus.grow || (bus.game_over && !prev_go)) begin
                if (ev_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: move_tick=%0d grow=%0d game_over=%0d, none expected (t=%0t)",
                             bus.move_tick, bus.grow, bus.game_over, $time);
                end else begin
                    e = ev_q.pop_front();
                    chk("ev_game_over", int'(bus.game_over), int'(e.dead));
                    chk("ev_move_tick", int'(bus.move_tick), int'(!e.dead));
                    chk("ev_head_x", int'(bus.head_x), e.hx);
                    chk("ev_head_y", int'(bus.head_y), e.hy);
                    chk("ev_length", int'(bus.length), e.len);
                    chk("ev_grow", int'(bus.grow), int'(e.grow));
                end
            end else if (ev_q.size() > 0) begin
                e = ev_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_event: got no move/death, expected dead=%0d head=(%0d,%0d) (t=%0t)",
                         e.dead, e.hx, e.hy, $time);
            end
            prev_go = bus.game_over;
        end
    end

    initial begin
        int d;
        rst_n = 1'b0;
        bus.dir_req = 2'd0;
        bus.dir_valid = 1'b0;
        bus.query_x = '0;
        bus.query_y = '0;
        set_apple(1, 1);
        model_reset();
        do_reset();
        repeat (6) cyc();

        // Plain movement to the right.
        req(1);
        wait_move();
        chk("s1_head_x_1", int'(bus.head_x), 11);
        wait_move();
        chk("s1_head_x_2", int'(bus.head_x), 12);
        chk("s1_length", int'(bus.length), 3);

        // A reversal is dropped; a turn up takes effect.
        req(3);
        wait_move();
        chk("s2_head_x", int'(bus.head_x), 13);
        req(0);
        wait_move();
        chk("s2_head_y", int'(bus.head_y), 9);

        // Eat on the first move; the old tail stays part of the body.
        do_reset();
        set_apple(11, 10);
        req(1);
        wait_move();
        set_apple(1, 1);
        chk("s3_length", int'(bus.length), 4);
        q_rand = 1'b0;
        bus.query_x = 6'd8;
        bus.query_y = 5'd10;
        cyc();
        q_rand = 1'b1;
        chk("s3_tail_query", int'(bus.query_hit), 1);

        // Tail chase at length 4 stays alive.
        for (int r = 0; r < 2; r++) begin
            req(2); wait_move();
            req(3); wait_move();
            req(0); wait_move();
            req(1); wait_move();
        end
        chk("s5_alive", int'(bus.game_over), 0);
        // The same loop dies once the tail cell holds the apple.
        for (int r = 0; r < 4 && m_state == 1; r++) begin
            d = (r == 0) ? 2 : (r == 1) ? 3 : (r == 2) ? 0 : 1;
            req(d);
            set_apple(bx[bx.size() - 1], by[by.size() - 1]);
            wait_move();
        end
        set_apple(1, 1);
        chk("s5_dead", int'(bus.game_over), 1);

        // Wall at the right edge.
        do_reset();
        req(0);
        repeat (5) wait_move();
        req(1);
        repeat (28) wait_move();
        chk("s4_head_x", int'(bus.head_x), 38);
        chk("s4_head_y", int'(bus.head_y), 5);
        wait_move();
        chk("s4_game_over", int'(bus.game_over), 1);
        for (int k = 0; k < 12; k++) req($urandom_range(0, 3));
        chk("s4_frozen_x", int'(bus.head_x), 38);
        chk("s4_frozen_y", int'(bus.head_y), 5);
        chk("s4_still_dead", int'(bus.game_over), 1);
        do_reset();
        repeat (10) cyc();

        // Grow to capacity; further apples move without growth.
        req(1);
        for (int k = 0; k < 15; k++) begin
            set_apple(bx[0] + 1, by[0]);
            wait_move();
        end
        set_apple(1, 1);
        chk("s6_length", int'(bus.length), MAXL);
        chk("s6_head_x", int'(bus.head_x), 25);
        repeat (2) cyc();
        do_reset();
        repeat (5) cyc();

        // Randomized play.
        for (int round = 0; round < 8; round++) begin
            do_reset();
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    d = $urandom_range(0, 3);
                    set_apple(bx[0] + ((d == 1) ? 1 : (d == 3) ? -1 : 0),
                              by[0] + ((d == 2) ? 1 : (d == 0) ? -1 : 0));
                end else if ($urandom_range(0, 7) == 0) begin
                    set_apple($urandom_range(0, 40), $urandom_range(0, 30));
                end
                if (!(m_state == 1 && m_cnt == T - 1) && $urandom_range(0, 3) == 0) begin
                    d = $urandom_range(0, 3);
                    if (m_state == 0 && d == 3) d = 1;
                    bus.dir_req = 2'(d);
                    bus.dir_valid = 1'b1;
                end
                if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
                cyc();
            end
        end

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
